pipe_reg_skid: RTL and testbench
================================

Name: pipe_reg_skid

Overview:
- Parametrised ready/valid pipeline stage. Generalises the plain enable/clear register into a 2-entry skid buffer with handshake and flush.
- Sustains one transfer per cycle. `ready_o` is fully registered, with no combinational path from `ready_i` to `ready_o`.
- Placed between core pipeline stages (IF1/IF2, IF/ID, ID/EX, ...) and on bus boundaries. Payload is carried as a packed struct of width `n`.

Parameters:
- `n`, default 32: payload width in bits (≥1).
- `RESET_VALUE`, default 0: value loaded into both data registers on reset.
- `CLR_VALUE`, default 0: value loaded into both data registers on flush (e.g. a NOP encoding).

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `reset_n`, input, 1: asynchronous active-low reset.
- `flush`, input, 1: synchronous clear. Empties the stage.
- `valid_i`, input, 1: upstream data valid.
- `ready_o`, output, 1: stage can accept. Registered; depends on state only.
- `data_i`, input, n: upstream payload.
- `valid_o`, output, 1: `data_o` is valid.
- `ready_i`, input, 1: downstream can accept.
- `data_o`, output, n: payload, driven by the main register.
- `count_o`, output, 2: occupancy, 0..2.

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Storage: a main register (drives `data_o`) and a skid register, each n bits. State register holds EMPTY, FULL or SKID.
- Events:
  - Accept = `valid_i & ready_o`.
  - Fire = `valid_o & ready_i`.
- Outputs decoded from state:
  - `valid_o` = (state != EMPTY).
  - `ready_o` = (state != SKID).
  - `count_o` = 0, 1 or 2 for EMPTY, FULL or SKID respectively.
- Reset (async, overrides all):
  - State EMPTY; main and skid registers = `RESET_VALUE`.
  - Hence `valid_o`=0, `ready_o`=1, `count_o`=0, `data_o`=`RESET_VALUE`.
  - Reset asserted mid-transfer discards all held data immediately.
- Flush (sync, priority over every handshake):
  - Next state EMPTY; both registers = `CLR_VALUE`.
  - Any accept in the same cycle is dropped, and upstream must treat it as lost.
  - A fire in that cycle still completes downstream (`data_o` was valid that cycle).
- Transitions when not flushing:
  - EMPTY:
    - Accept → main ← `data_i`, go to FULL.
    - Otherwise hold.
  - FULL:
    - Accept & fire → main ← `data_i`, stay FULL.
    - Accept & !fire → skid ← `data_i`, go to SKID.
    - !accept & fire → go to EMPTY. Main keeps its stale value.
    - Neither → hold.
  - SKID (`ready_o`=0, so accept is impossible):
    - Fire → main ← skid, go to FULL.
    - Otherwise hold both.
- Latency and throughput:
  - Latency is 1 cycle from accept to `valid_o`. There is no combinational bypass from `data_i` to `data_o`, even when EMPTY.
  - Back-to-back throughput is 1 transfer/cycle with `ready_i` held high.
- Ordering: strict FIFO. No data is lost or duplicated when `ready_i` drops. The skid entry absorbs the one in-flight beat.
- Stability: while `valid_o`=1 and `ready_i`=0, `data_o` and `valid_o` hold constant.
- Don't-care inputs:
  - `data_i` is ignored when `valid_i`=0.
  - `valid_i` is ignored while `ready_o`=0.
  - `data_o` is unspecified-but-stable while `valid_o`=0: it holds its last value.
- Illegal state encoding (if any) must recover to EMPTY on the next clock.

Test Plan:
- Reset: assert `reset_n`=0 mid-stream in SKID holding 0xA, 0xB, with `RESET_VALUE`=0x13 → immediately `valid_o`=0, `ready_o`=1, `count_o`=0, `data_o`=0x13. Release, then one idle cycle → no spurious `valid_o`.
- Streaming: `ready_i`=1, `valid_i`=1 with data 1,2,3,4,5 on consecutive cycles → `data_o` shows 1..5 one cycle later, one per cycle; `ready_o` stays 1; `count_o` stays 1.
- Backpressure/skid: stream 0x10,0x11,0x12,...; drop `ready_i` for 3 cycles when `data_o`=0x10 → next cycle `count_o`=2, `ready_o`=0, skid holds 0x11, `data_o` stays 0x10. Raise `ready_i` → outputs 0x10, 0x11, 0x12 in order with no gap or duplicate.
- Drain: FULL with 0x55, `valid_i`=0, `ready_i`=1 → next cycle `valid_o`=0, `count_o`=0, `ready_o`=1.
- Flush: in SKID holding 0x20/0x21, assert `flush` with `valid_i`=1 and data 0x22, `CLR_VALUE`=0x13 → next cycle EMPTY, `data_o`=0x13, `valid_o`=0; 0x20/0x21/0x22 never appear.
- Random: random `valid_i`/`ready_i` for 10k cycles, no flush → scoreboard shows output sequence equal to accepted sequence; `data_o` stable under stall; `count_o` equals accepts minus fires.

Source files
------------

// File: rtl/pipe_reg_skid.sv
// Ready/valid pipeline stage built as a 2-entry skid buffer with synchronous flush.
// ready_o is decoded purely from registered state, so there is no ready_i -> ready_o path.
module pipe_reg_skid #(
    parameter int unsigned     n           = 32,
    parameter logic [n-1:0]    RESET_VALUE = '0,
    parameter logic [n-1:0]    CLR_VALUE   = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [n-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [n-1:0] data_o,
    output logic [1:0]   count_o
);

    typedef enum logic [1:0] {
        Empty = 2'b00,
        Full  = 2'b01,
        Skid  = 2'b10
    } state_e;

    state_e       state;
    logic [n-1:0] main_q;
    logic [n-1:0] skid_q;
    logic         accept;
    logic         fire;

    assign accept = valid_i & ready_o;
    assign fire   = valid_o & ready_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= Empty;
            main_q <= RESET_VALUE;
            skid_q <= RESET_VALUE;
        end else if (flush) begin
            // A same-cycle accept is dropped; a same-cycle fire has already completed.
            state  <= Empty;
            main_q <= CLR_VALUE;
            skid_q <= CLR_VALUE;
        end else begin
            case (state)
                Empty: begin
                    if (accept) begin
                        main_q <= data_i;
                        state  <= Full;
                    end
                end
                Full: begin
                    if (accept && fire) begin
                        main_q <= data_i;
                    end else if (accept) begin
                        skid_q <= data_i;
                        state  <= Skid;
                    end else if (fire) begin
                        state  <= Empty;
                    end
                end
                Skid: begin
                    if (fire) begin
                        main_q <= skid_q;
                        state  <= Full;
                    end
                end
                default: state <= Empty;
            endcase
        end
    end

    always_comb begin
        valid_o = (state != Empty);
        ready_o = (state != Skid);
        count_o = 2'd0;
        case (state)
            Full:    count_o = 2'd1;
            Skid:    count_o = 2'd2;
            default: count_o = 2'd0;
        endcase
    end

    assign data_o = main_q;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed vector table plus reset/random sequences for pipe_reg_skid.
module tb_pipe_reg_skid;

    localparam int unsigned N = 8;
    localparam logic [N-1:0] RV = 8'h13;
    localparam logic [N-1:0] CV = 8'h13;

    logic         clk;
    logic         reset_n;
    logic         flush;
    logic         valid_i;
    logic         ready_o;
    logic [N-1:0] data_i;
    logic         valid_o;
    logic         ready_i;
    logic [N-1:0] data_o;
    logic [1:0]   count_o;

    int checks;
    int failures;

    pipe_reg_skid #(
        .n           (N),
        .RESET_VALUE (RV),
        .CLR_VALUE   (CV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .count_o (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         fl;
        logic         vi;
        logic         ri;
        logic [N-1:0] di;
        logic         ev;
        logic         er;
        logic [1:0]   ec;
        logic [N-1:0] ed;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string nm, input logic ev, input logic er,
                              input logic [1:0] ec, input logic [N-1:0] ed);
        check({nm, "_valid"}, int'(valid_o), int'(ev));
        check({nm, "_ready"}, int'(ready_o), int'(er));
        check({nm, "_count"}, int'(count_o), int'(ec));
        check({nm, "_data"},  int'(data_o),  int'(ed));
    endtask

    logic [N-1:0] sb[$];
    logic [N-1:0] next_val;
    logic [N-1:0] prev_data;
    logic         prev_stall;
    logic         acc;
    logic         fir;

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        flush    = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        data_i   = '0;

        //            fl  vi  ri  di     ev  er  ec  ed
        // streaming 1..5 then drain
        vecs.push_back('{0, 1, 1, 8'h01, 1, 1, 1, 8'h01});
        vecs.push_back('{0, 1, 1, 8'h02, 1, 1, 1, 8'h02});
        vecs.push_back('{0, 1, 1, 8'h03, 1, 1, 1, 8'h03});
        vecs.push_back('{0, 1, 1, 8'h04, 1, 1, 1, 8'h04});
        vecs.push_back('{0, 1, 1, 8'h05, 1, 1, 1, 8'h05});
        vecs.push_back('{0, 0, 1, 8'h00, 0, 1, 0, 8'h05});
        // backpressure: ready_i low for 3 cycles while data_o = 0x10
        vecs.push_back('{0, 1, 1, 8'h10, 1, 1, 1, 8'h10});
        vecs.push_back('{0, 1, 0, 8'h11, 1, 0, 2, 8'h10});
        vecs.push_back('{0, 1, 0, 8'h12, 1, 0, 2, 8'h10});
        vecs.push_back('{0, 1, 0, 8'h12, 1, 0, 2, 8'h10});
        vecs.push_back('{0, 1, 1, 8'h12, 1, 1, 1, 8'h11});
        vecs.push_back('{0, 1, 1, 8'h12, 1, 1, 1, 8'h12});
        vecs.push_back('{0, 0, 1, 8'h00, 0, 1, 0, 8'h12});
        // drain from FULL 0x55
        vecs.push_back('{0, 1, 0, 8'h55, 1, 1, 1, 8'h55});
        vecs.push_back('{0, 0, 1, 8'h00, 0, 1, 0, 8'h55});
        // flush in SKID with a pending accept
        vecs.push_back('{0, 1, 1, 8'h20, 1, 1, 1, 8'h20});
        vecs.push_back('{0, 1, 0, 8'h21, 1, 0, 2, 8'h20});
        vecs.push_back('{1, 1, 0, 8'h22, 0, 1, 0, CV});
        vecs.push_back('{0, 0, 1, 8'h22, 0, 1, 0, CV});
        // flush in FULL with accept and fire both active
        vecs.push_back('{0, 1, 1, 8'h30, 1, 1, 1, 8'h30});
        vecs.push_back('{1, 1, 1, 8'h31, 0, 1, 0, CV});
        // data_i ignored while valid_i low
        vecs.push_back('{0, 0, 0, 8'hAA, 0, 1, 0, CV});

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 1'b1, 2'd0, RV);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_outs("post_reset_idle", 1'b0, 1'b1, 2'd0, RV);

        for (int i = 0; i < vecs.size(); i++) begin
            flush   = vecs[i].fl;
            valid_i = vecs[i].vi;
            ready_i = vecs[i].ri;
            data_i  = vecs[i].di;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].ec, vecs[i].ed);
        end

        // Asynchronous reset while holding 0x0A/0x0B in SKID
        flush   = 1'b0;
        valid_i = 1'b1;
        ready_i = 1'b0;
        data_i  = 8'h0A;
        tick();
        data_i  = 8'h0B;
        tick();
        check_outs("pre_async_reset", 1'b1, 1'b0, 2'd2, 8'h0A);
        valid_i = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("async_reset", 1'b0, 1'b1, 2'd0, RV);
        @(negedge clk);
        reset_n = 1'b1;
        ready_i = 1'b1;
        tick();
        check_outs("async_reset_idle", 1'b0, 1'b1, 2'd0, RV);

        // Random handshake scoreboard
        next_val   = 8'h40;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            valid_i = 1'($urandom_range(0, 1));
            ready_i = 1'($urandom_range(0, 1));
            data_i  = valid_i ? next_val : 8'($urandom);
            #1;
            check("rnd_count", int'(count_o), sb.size());
            check("rnd_valid", int'(valid_o), int'(sb.size() != 0));
            check("rnd_ready", int'(ready_o), int'(sb.size() < 2));
            if (prev_stall) check("rnd_stall_data", int'(data_o), int'(prev_data));
            acc = valid_i & ready_o;
            fir = valid_o & ready_i;
            if (fir) begin
                if (sb.size() == 0) begin
                    check("rnd_fire_empty", 1, 0);
                end else begin
                    check("rnd_order", int'(data_o), int'(sb[0]));
                    void'(sb.pop_front());
                end
            end
            if (acc) begin
                sb.push_back(data_i);
                next_val = next_val + 8'd1;
            end
            prev_stall = valid_o & ~ready_i;
            prev_data  = data_o;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
